// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the two-master RAM arbiter: bus widths, RAM geometry,
// and the master-index encoding used by the grant logic and response path.
package ram_arbiter_pkg;

   localparam int ADDR_WIDTH     = 32;
   localparam int DATA_WIDTH     = 32;
   localparam int RAM_ADDR_WIDTH = 10;
   localparam int RAM_SIZE       = 1 << RAM_ADDR_WIDTH;

   localparam logic                  WRITE_ENABLE = 1'b1;
   localparam logic [DATA_WIDTH-1:0] ZERO         = '0;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

endpackage : ram_arbiter_pkg

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the fetch master, the load/store master, the arbiter and the RAM.
// The slave modport is the arbiter's view; master is the view of the agents around it.
interface ram_arbiter_if #(
   parameter int ADDR_WIDTH = ram_arbiter_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = ram_arbiter_pkg::DATA_WIDTH
);

   logic                  m0_req_i;
   logic [ADDR_WIDTH-1:0] m0_addr_i;
   logic                  m0_gnt_o;
   logic                  m0_rvalid_o;
   logic [DATA_WIDTH-1:0] m0_rdata_o;
   logic                  m0_err_o;

   logic                  m1_req_i;
   logic                  m1_we_i;
   logic [ADDR_WIDTH-1:0] m1_addr_i;
   logic [DATA_WIDTH-1:0] m1_wdata_i;
   logic                  m1_gnt_o;
   logic                  m1_rvalid_o;
   logic [DATA_WIDTH-1:0] m1_rdata_o;
   logic                  m1_err_o;

   logic                  ram_we_o;
   logic [ADDR_WIDTH-1:0] ram_addr_o;
   logic [DATA_WIDTH-1:0] ram_wdata_o;
   logic [DATA_WIDTH-1:0] ram_rdata_i;

   modport slave (
      input  m0_req_i, m0_addr_i,
      output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
      input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
      output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
      output ram_we_o, ram_addr_o, ram_wdata_o,
      input  ram_rdata_i
   );

   modport master (
      output m0_req_i, m0_addr_i,
      input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
      output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
      input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
      input  ram_we_o, ram_addr_o, ram_wdata_o,
      output ram_rdata_i
   );

endinterface : ram_arbiter_if

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-request round-robin grant: under contention the master that did not win
// last time is chosen; last_q only moves when a request is actually accepted.
module rr_arb2
   import ram_arbiter_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1,
   output logic winner,
   output logic accept
);

   logic last_q;

   always_comb begin
      winner = M0;
      if (req0 && req1) begin
         winner = (last_q == M0) ? M1 : M0;
      end else if (req1) begin
         winner = M1;
      end
   end

   assign accept = req0 | req1;
   assign gnt0   = accept & (winner == M0);
   assign gnt1   = accept & (winner == M1);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; reset to M1 makes m0 the first contention winner.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= M1;
      end else if (accept) begin
         last_q <= winner;
      end
   end

endmodule : rr_arb2

// File: rtl/ram_arbiter.sv
// Shares one combinational-read / synchronous-write word RAM between fetch (m0)
// and load/store (m1): round-robin grant, legality filter, registered one-cycle responses.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH     = ram_arbiter_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH     = ram_arbiter_pkg::DATA_WIDTH,
   parameter int RAM_ADDR_WIDTH = ram_arbiter_pkg::RAM_ADDR_WIDTH
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   ram_arbiter_if.slave  bus
);

   // Only the word-index bits may be set; alignment bits and anything above the RAM are illegal.
   localparam logic [ADDR_WIDTH-1:0] LEGAL_MASK =
      ADDR_WIDTH'(((64'd1 << (RAM_ADDR_WIDTH + 2)) - 64'd1) & ~64'd3);

   logic                  req0, req1;
   logic                  gnt0, gnt1, winner, accept;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  sel_write;
   logic                  legal;
   logic [DATA_WIDTH-1:0] rsp_data;

   logic                  m0_rvalid_q, m1_rvalid_q;
   logic [DATA_WIDTH-1:0] m0_rdata_q,  m1_rdata_q;
   logic                  m0_err_q,    m1_err_q;

   // NOTE: requests are gated by reset so an asserted rst_ni drops the grant and
   // blocks a same-cycle RAM write combinationally, not just at the next edge.
   assign req0 = bus.m0_req_i & rst_ni;
   assign req1 = bus.m1_req_i & rst_ni;

   rr_arb2 u_rr_arb2 (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req0   (req0),
      .req1   (req1),
      .gnt0   (gnt0),
      .gnt1   (gnt1),
      .winner (winner),
      .accept (accept)
   );

   always_comb begin
      sel_addr  = '0;
      sel_wdata = DATA_WIDTH'(ZERO);
      sel_write = 1'b0;
      if (accept) begin
         if (winner == M1) begin
            sel_addr  = bus.m1_addr_i;
            sel_wdata = bus.m1_wdata_i;
            sel_write = (bus.m1_we_i == WRITE_ENABLE);
         end else begin
            sel_addr  = bus.m0_addr_i;
         end
      end
   end

   assign legal    = (sel_addr & ~LEGAL_MASK) == '0;
   assign rsp_data = (legal && !sel_write) ? bus.ram_rdata_i : DATA_WIDTH'(ZERO);

   assign bus.m0_gnt_o    = gnt0;
   assign bus.m1_gnt_o    = gnt1;
   assign bus.ram_we_o    = sel_write & legal;
   assign bus.ram_addr_o  = sel_addr;
   assign bus.ram_wdata_o = sel_wdata;

   // rvalid pulses for one cycle; rdata/err are only reloaded on a response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
         m0_err_q    <= 1'b0;
         m1_err_q    <= 1'b0;
      end else begin
         m0_rvalid_q <= gnt0;
         m1_rvalid_q <= gnt1;
         if (gnt0) begin
            m0_rdata_q <= rsp_data;
            m0_err_q   <= ~legal;
         end
         if (gnt1) begin
            m1_rdata_q <= rsp_data;
            m1_err_q   <= ~legal;
         end
      end
   end

   assign bus.m0_rvalid_o = m0_rvalid_q;
   assign bus.m0_rdata_o  = m0_rdata_q;
   assign bus.m0_err_o    = m0_err_q;
   assign bus.m1_rvalid_o = m1_rvalid_q;
   assign bus.m1_rdata_o  = m1_rdata_q;
   assign bus.m1_err_o    = m1_err_q;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios then randomized traffic, every cycle
// compared against a transaction-level model (who should win, what the RAM should hold).
module tb_ram_arbiter;

   localparam int RAM_WORDS = 1024;
   localparam int RAM_BYTES = 4 * RAM_WORDS;

   logic clk_i = 1'b0;
   logic rst_ni;

   always #5 clk_i = ~clk_i;

   ram_arbiter_if bus ();

   ram_arbiter u_dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   // RAM attached to the arbiter: combinational read, write on the clock edge.
   logic [31:0] ram_mem [RAM_WORDS];
   assign bus.ram_rdata_i = ram_mem[bus.ram_addr_o[11:2]];
   always @(posedge clk_i) begin
      if (bus.ram_we_o) ram_mem[bus.ram_addr_o[11:2]] <= bus.ram_wdata_o;
   end

   // Reference model state.
   logic [31:0] ref_mem [RAM_WORDS];
   int          last_w;
   logic        exp_rv0, exp_rv1, exp_err0, exp_err1;
   logic [31:0] exp_rd0, exp_rd1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic is_legal(input logic [31:0] a);
      return (a % 4 == 0) && (a < RAM_BYTES);
   endfunction

   function automatic logic [31:0] rand_addr();
      int unsigned idx = $urandom_range(0, 15);
      case ($urandom_range(0, 9))
         0:       return idx * 4 + $urandom_range(1, 3);
         1:       return 32'h1000 + idx * 4;
         2:       return 32'h8000_0000 | (idx * 4);
         3:       return 32'hFFC;
         default: return idx * 4;
      endcase
   endfunction

   task automatic model_reset();
      last_w   = 1;
      exp_rv0  = 1'b0;
      exp_rv1  = 1'b0;
      exp_rd0  = '0;
      exp_rd1  = '0;
      exp_err0 = 1'b0;
      exp_err1 = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_m0_gnt"},    bus.m0_gnt_o,    1'b0);
      check({tag, "_m1_gnt"},    bus.m1_gnt_o,    1'b0);
      check({tag, "_m0_rvalid"}, bus.m0_rvalid_o, 1'b0);
      check({tag, "_m1_rvalid"}, bus.m1_rvalid_o, 1'b0);
      check({tag, "_m0_rdata"},  bus.m0_rdata_o,  32'h0);
      check({tag, "_m1_rdata"},  bus.m1_rdata_o,  32'h0);
      check({tag, "_m0_err"},    bus.m0_err_o,    1'b0);
      check({tag, "_m1_err"},    bus.m1_err_o,    1'b0);
      check({tag, "_ram_we"},    bus.ram_we_o,    1'b0);
   endtask

   // One bus cycle: drive requests, compare grant/RAM drive for this cycle and
   // the response owed from the previous one, then advance the model.
   task automatic cycle(input logic r0, input logic [31:0] a0,
                        input logic r1, input logic we, input logic [31:0] a1,
                        input logic [31:0] wd, output logic g0, output logic g1);
      int          win;
      logic [31:0] wa;
      logic        lg;
      logic [31:0] rd;
      bus.m0_req_i   = r0;
      bus.m0_addr_i  = a0;
      bus.m1_req_i   = r1;
      bus.m1_we_i    = we;
      bus.m1_addr_i  = a1;
      bus.m1_wdata_i = wd;
      #2;
      win = -1;
      if (r0 && r1)  win = (last_w == 1) ? 0 : 1;
      else if (r0)   win = 0;
      else if (r1)   win = 1;
      wa = (win == 0) ? a0 : (win == 1) ? a1 : 32'h0;
      lg = is_legal(wa);

      check("m0_gnt",    bus.m0_gnt_o,    win == 0);
      check("m1_gnt",    bus.m1_gnt_o,    win == 1);
      check("ram_we",    bus.ram_we_o,    (win == 1) && we && lg);
      check("ram_addr",  bus.ram_addr_o,  wa);
      if ((win == 1) && we && lg) check("ram_wdata", bus.ram_wdata_o, wd);
      check("m0_rvalid", bus.m0_rvalid_o, exp_rv0);
      check("m0_rdata",  bus.m0_rdata_o,  exp_rd0);
      check("m0_err",    bus.m0_err_o,    exp_err0);
      check("m1_rvalid", bus.m1_rvalid_o, exp_rv1);
      check("m1_rdata",  bus.m1_rdata_o,  exp_rd1);
      check("m1_err",    bus.m1_err_o,    exp_err1);

      exp_rv0 = (win == 0);
      exp_rv1 = (win == 1);
      if (win >= 0) begin
         rd = (lg && !((win == 1) && we)) ? ref_mem[wa[11:2]] : 32'h0;
         if (win == 0) begin
            exp_rd0  = rd;
            exp_err0 = !lg;
         end else begin
            exp_rd1  = rd;
            exp_err1 = !lg;
         end
         if ((win == 1) && we && lg) ref_mem[wa[11:2]] = wd;
         last_w = win;
      end
      g0 = (win == 0);
      g1 = (win == 1);
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      logic g0, g1;
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g0, g1);
   endtask

   initial begin
      logic        g0, g1;
      logic        r0, r1, we1;
      logic [31:0] a0, a1, wd1;

      rst_ni         = 1'b0;
      bus.m0_req_i   = 1'b0;
      bus.m0_addr_i  = '0;
      bus.m1_req_i   = 1'b0;
      bus.m1_we_i    = 1'b0;
      bus.m1_addr_i  = '0;
      bus.m1_wdata_i = '0;
      for (int i = 0; i < RAM_WORDS; i++) begin
         ram_mem[i] = $urandom();
         ref_mem[i] = ram_mem[i];
      end
      ram_mem[0] = 32'hDEADBEEF;
      ref_mem[0] = 32'hDEADBEEF;
      model_reset();

      #1;
      bus.m0_req_i = 1'b1;
      bus.m1_req_i = 1'b1;
      bus.m1_we_i  = 1'b1;
      #1;
      check_quiet("por");
      bus.m0_req_i = 1'b0;
      bus.m1_req_i = 1'b0;
      bus.m1_we_i  = 1'b0;
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      // Fetch of the preloaded word.
      cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g0, g1);
      idle();

      // Sustained contention.
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'h0, g0, g1);
      idle();

      // Read-after-write across masters.
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h12345678, g0, g1);
      cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, g0, g1);
      idle();

      // Illegal writes are granted, flagged and dropped; top word and oversize reads.
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h2, 32'hBAD00001, g0, g1);
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h1000, 32'hBAD00002, g0, g1);
      cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g0, g1);
      cycle(1'b1, 32'h1004, 1'b1, 1'b0, 32'hFFC, 32'h0, g0, g1);
      cycle(1'b1, 32'h1004, 1'b1, 1'b0, 32'hFFC, 32'h0, g0, g1);
      idle();

      // m1 write loses contention, holds, commits once on the next cycle.
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, g0, g1);
      cycle(1'b1, 32'h24, 1'b1, 1'b1, 32'h28, 32'hCAFEF00D, g0, g1);
      check("held_write_lost", g1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h28, 32'hCAFEF00D, g0, g1);
      cycle(1'b1, 32'h28, 1'b0, 1'b0, 32'h0, 32'h0, g0, g1);
      idle();

      // Reset asserted the cycle after an m0 grant, with a write pending.
      cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, g0, g1);
      rst_ni         = 1'b0;
      bus.m0_req_i   = 1'b1;
      bus.m1_req_i   = 1'b1;
      bus.m1_we_i    = 1'b1;
      bus.m1_addr_i  = 32'h0;
      bus.m1_wdata_i = 32'hFFFFFFFF;
      #2;
      check_quiet("midrst");
      model_reset();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      cycle(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, g0, g1);
      check("post_rst_m0_first", g0, 1'b1);
      idle();

      // Randomized traffic; an ungranted master keeps its request unchanged.
      r0  = 1'b1;  a0 = rand_addr();
      r1  = 1'b1;  we1 = 1'b1;  a1 = rand_addr();  wd1 = $urandom();
      for (int i = 0; i < 400; i++) begin
         cycle(r0, a0, r1, we1, a1, wd1, g0, g1);
         if (!r0 || g0) begin
            r0 = ($urandom_range(0, 3) != 0);
            a0 = rand_addr();
         end
         if (!r1 || g1) begin
            r1  = ($urandom_range(0, 3) != 0);
            we1 = $urandom_range(0, 1);
            a1  = rand_addr();
            wd1 = $urandom();
         end
      end
      idle();

      // Final sweep of the low words through m0 against the reference contents.
      for (int i = 0; i < 16; i++) cycle(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0, g0, g1);
      idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_ram_arbiter
